// File: rtl/fp_addsub_seq.sv
// Multi-cycle floating-point add/subtract with round-to-nearest-even and special-value handling.
// Latency: 6 cycles start->done plus one per normalise left shift; specials 3 cycles. start is ignored while busy.
module fp_addsub_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   op_sub,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   neg,
    output logic                   zero,
    output logic                   carry,
    output logic                   overflow,
    output logic                   invalid
);
    localparam int W  = EXP_W + MAN_W + 1;
    localparam int M  = MAN_W + 5;
    localparam int XW = EXP_W + 2;

    localparam logic [EXP_W-1:0]      EXP_ONES = '1;
    localparam logic signed [XW-1:0]  EMAX     = {2'b00, {EXP_W{1'b1}}};
    localparam logic signed [XW-1:0]  ONE      = 1;
    localparam logic signed [XW-1:0]  ZERO     = 0;
    localparam logic [XW-1:0]         D_MAX    = XW'(MAN_W + 3);
    localparam logic [W-1:0]          QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [W-1:0]           opa_q, opa_d, opb_q, opb_d;
    logic                   sa_q, sa_d, sb_q, sb_d;
    logic signed [XW-1:0]   ea_q, ea_d;
    logic [M-1:0]           ma_q, ma_d, mb_q, mb_d;
    logic [XW-1:0]          d_q, d_d;
    logic                   spec_q, spec_d, spec_inv_q, spec_inv_d;
    logic [W-1:0]           spec_res_q, spec_res_d;
    logic                   busy_q, busy_d, done_q, done_d;
    logic [W-1:0]           res_q, res_d;
    logic                   neg_q, neg_d, zero_q, zero_d, ovf_q, ovf_d, inv_q, inv_d;

    // Operand decode; exponent 0 is treated as zero (denormals flushed).
    logic [EXP_W-1:0] ua_e, ub_e, u_big_e, u_small_e;
    logic [MAN_W-1:0] ua_f, ub_f;
    logic [W-2:0]     ua_mag, ub_mag;
    logic             ua_z, ub_z, ua_inf, ub_inf, ua_nan, ub_nan, u_swap;

    assign ua_e      = opa_q[W-2:MAN_W];
    assign ub_e      = opb_q[W-2:MAN_W];
    assign ua_f      = opa_q[MAN_W-1:0];
    assign ub_f      = opb_q[MAN_W-1:0];
    assign ua_z      = (ua_e == '0);
    assign ub_z      = (ub_e == '0);
    assign ua_inf    = (ua_e == EXP_ONES) && (ua_f == '0);
    assign ub_inf    = (ub_e == EXP_ONES) && (ub_f == '0);
    assign ua_nan    = (ua_e == EXP_ONES) && (ua_f != '0);
    assign ub_nan    = (ub_e == EXP_ONES) && (ub_f != '0);
    assign ua_mag    = ua_z ? '0 : opa_q[W-2:0];
    assign ub_mag    = ub_z ? '0 : opb_q[W-2:0];
    assign u_swap    = (ub_mag > ua_mag);
    assign u_big_e   = u_swap ? ub_e : ua_e;
    assign u_small_e = u_swap ? ua_e : ub_e;

    logic [M-1:0] al_sh, al_mask, sum;
    logic         al_sticky;

    assign al_sh     = mb_q >> d_q;
    assign al_mask   = ~({M{1'b1}} << d_q);
    assign al_sticky = |(mb_q & al_mask);
    assign sum       = (sa_q == sb_q) ? (ma_q + mb_q) : (ma_q - mb_q);

    // Rounding: operate on {carry, hidden, frac}, G/R/S in the low three bits.
    logic                 rnd_inc;
    logic [MAN_W+1:0]     rnd_m;
    logic signed [XW-1:0] rnd_e;
    logic [MAN_W-1:0]     rnd_f;

    assign rnd_inc = ma_q[2] & (ma_q[1] | ma_q[0] | ma_q[3]);
    assign rnd_m   = ma_q[M-1:3] + {{(MAN_W+1){1'b0}}, rnd_inc};
    assign rnd_e   = ea_q + (rnd_m[MAN_W+1] ? ONE : ZERO);
    assign rnd_f   = rnd_m[MAN_W+1] ? rnd_m[MAN_W:1] : rnd_m[MAN_W-1:0];

    always_comb begin
        state_d    = state_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        sa_d       = sa_q;
        sb_d       = sb_q;
        ea_d       = ea_q;
        ma_d       = ma_q;
        mb_d       = mb_q;
        d_d        = d_q;
        spec_d     = spec_q;
        spec_inv_d = spec_inv_q;
        spec_res_d = spec_res_q;
        res_d      = res_q;
        neg_d      = neg_q;
        zero_d     = zero_q;
        ovf_d      = ovf_q;
        inv_d      = inv_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    opa_d   = a;
                    opb_d   = b ^ {op_sub, {(W-1){1'b0}}};
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                sa_d       = u_swap ? opb_q[W-1] : opa_q[W-1];
                sb_d       = u_swap ? opa_q[W-1] : opb_q[W-1];
                ea_d       = signed'({2'b00, u_big_e});
                ma_d       = {2'b01, (u_swap ? ub_f : ua_f), 3'b000};
                mb_d       = {2'b01, (u_swap ? ua_f : ub_f), 3'b000};
                d_d        = {2'b00, u_big_e} - {2'b00, u_small_e};
                spec_d     = 1'b1;
                spec_inv_d = 1'b0;
                if (ua_nan || ub_nan || (ua_inf && ub_inf && (opa_q[W-1] != opb_q[W-1]))) begin
                    spec_res_d = QNAN;
                    spec_inv_d = 1'b1;
                end else if (ua_inf) begin
                    spec_res_d = opa_q;
                end else if (ub_inf) begin
                    spec_res_d = opb_q;
                end else if (ua_z && ub_z) begin
                    spec_res_d = {opa_q[W-1] & opb_q[W-1], {(W-1){1'b0}}};
                end else if (ua_z) begin
                    spec_res_d = opb_q;
                end else if (ub_z) begin
                    spec_res_d = opa_q;
                end else begin
                    spec_d = 1'b0;
                end
                state_d = S_ALIGN;
            end
            S_ALIGN: begin
                // Classification was registered last cycle; specials leave here.
                if (spec_q) begin
                    res_d   = spec_res_q;
                    neg_d   = spec_res_q[W-1];
                    zero_d  = (spec_res_q[W-2:0] == '0);
                    ovf_d   = 1'b0;
                    inv_d   = spec_inv_q;
                    state_d = S_DONE;
                end else begin
                    if (d_q >= D_MAX) begin
                        mb_d = {{(M-1){1'b0}}, |mb_q};
                    end else begin
                        mb_d = {al_sh[M-1:1], al_sh[0] | al_sticky};
                    end
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                if (sum == '0) begin
                    ma_d    = '0;
                    ea_d    = ZERO;
                    sa_d    = 1'b0;
                    state_d = S_ROUND;
                end else begin
                    ma_d    = sum;
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                if (ma_q[M-1]) begin
                    ma_d    = {1'b0, ma_q[M-1:2], ma_q[1] | ma_q[0]};
                    ea_d    = ea_q + ONE;
                    state_d = S_ROUND;
                end else if (ma_q[M-2]) begin
                    state_d = S_ROUND;
                end else if (ea_q <= ONE) begin
                    res_d   = {sa_q, {(W-1){1'b0}}};
                    neg_d   = sa_q;
                    zero_d  = 1'b1;
                    ovf_d   = 1'b0;
                    inv_d   = 1'b0;
                    state_d = S_DONE;
                end else begin
                    ma_d = ma_q << 1;
                    ea_d = ea_q - ONE;
                end
            end
            S_ROUND: begin
                if (rnd_e >= EMAX) begin
                    res_d = {sa_q, EXP_ONES, {MAN_W{1'b0}}};
                    ovf_d = 1'b1;
                end else begin
                    res_d = {sa_q, rnd_e[EXP_W-1:0], rnd_f};
                    ovf_d = 1'b0;
                end
                neg_d   = sa_q;
                zero_d  = (rnd_e < EMAX) && (rnd_e == ZERO) && (rnd_f == '0);
                inv_d   = 1'b0;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            opa_q      <= '0;
            opb_q      <= '0;
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
            ea_q       <= '0;
            ma_q       <= '0;
            mb_q       <= '0;
            d_q        <= '0;
            spec_q     <= 1'b0;
            spec_inv_q <= 1'b0;
            spec_res_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            res_q      <= '0;
            neg_q      <= 1'b0;
            zero_q     <= 1'b0;
            ovf_q      <= 1'b0;
            inv_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            sa_q       <= sa_d;
            sb_q       <= sb_d;
            ea_q       <= ea_d;
            ma_q       <= ma_d;
            mb_q       <= mb_d;
            d_q        <= d_d;
            spec_q     <= spec_d;
            spec_inv_q <= spec_inv_d;
            spec_res_q <= spec_res_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            res_q      <= res_d;
            neg_q      <= neg_d;
            zero_q     <= zero_d;
            ovf_q      <= ovf_d;
            inv_q      <= inv_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = res_q;
    assign neg      = neg_q;
    assign zero     = zero_q;
    assign carry    = 1'b0;
    assign overflow = ovf_q;
    assign invalid  = inv_q;

endmodule
